// File: rtl/mcp_send_fifo.sv
// MCP CDC sender: input FIFO, held data bus plus toggle enable, toggle-ack retire.
// Optional ack-wait watchdog enabled by defining MCP_SEND_TIMEOUT_EN.
module mcp_send_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       aclk,
  input  logic                       arst,
  input  logic [WIDTH-1:0]           ain_data,
  input  logic                       ain_valid,
  output logic                       ain_ready,
  input  logic                       aq2_ack,
  output logic [WIDTH-1:0]           adata,
  output logic                       a_en,
  output logic                       abusy,
  output logic [$clog2(DEPTH+1)-1:0] acount,
  output logic                       atimeout
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_adata;
  logic             r_a_en;
  logic             r_aq3;

  logic w_full;
  logic w_empty;
  logic w_aack;
  logic w_push;
  logic w_launch;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                   (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
  assign w_aack  = aq2_ack ^ r_aq3;
  assign w_push  = ain_valid && !w_full;
  // An ack seen in IDLE is spurious and must not trigger anything.
  assign w_launch = !w_empty &&
                    ((r_state == S_IDLE) ||
                     (r_state == S_WAIT && w_aack));

  assign ain_ready = !w_full;
  assign adata     = r_adata;
  assign a_en      = r_a_en;
  assign abusy     = (r_state == S_WAIT);
  assign acount    = r_count;

  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[r_wptr[PW-2:0]] <= ain_data;
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_adata <= '0;
      r_a_en  <= 1'b0;
      r_aq3   <= 1'b0;
    end else begin
      r_aq3 <= aq2_ack;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_launch) begin
        r_rptr  <= r_rptr + 1'b1;
        r_adata <= r_mem[r_rptr[PW-2:0]];
        r_a_en  <= ~r_a_en;
        r_state <= S_WAIT;
      end else if (r_state == S_WAIT && w_aack) begin
        r_state <= S_IDLE;
      end
      unique case ({w_push, w_launch})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef MCP_SEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  logic [TW-1:0] r_tcnt;
  logic          r_tout;

  // Counter saturates at TIMEOUT; the flag is sticky until reset.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_tcnt <= '0;
      r_tout <= 1'b0;
    end else if (w_launch) begin
      r_tcnt <= '0;
    end else if (r_state == S_WAIT && r_tcnt != TMAX) begin
      r_tcnt <= r_tcnt + 1'b1;
      if (r_tcnt == TMAX - 1'b1) begin
        r_tout <= 1'b1;
      end
    end
  end

  assign atimeout = r_tout;
`else
  assign atimeout = 1'b0;
`endif

endmodule

// File: tb/tb_mcp_send_fifo.sv
// Self-checking bench for mcp_send_fifo: directed scenarios plus
// randomized traffic against a queue-based transfer model.
module tb_mcp_send_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 10;

  logic             aclk = 1'b0;
  logic             arst;
  logic [WIDTH-1:0] ain_data;
  logic             ain_valid;
  logic             ain_ready;
  logic             aq2_ack;
  logic [WIDTH-1:0] adata;
  logic             a_en;
  logic             abusy;
  logic [2:0]       acount;
  logic             atimeout;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] q[$];
  logic             m_busy;
  logic             m_en;
  logic [WIDTH-1:0] m_data;
  logic             m_prev;

  mcp_send_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .TIMEOUT(TMO)
  ) dut (
    .aclk(aclk),
    .arst(arst),
    .ain_data(ain_data),
    .ain_valid(ain_valid),
    .ain_ready(ain_ready),
    .aq2_ack(aq2_ack),
    .adata(adata),
    .a_en(a_en),
    .abusy(abusy),
    .acount(acount),
    .atimeout(atimeout)
  );

  always #5 aclk = ~aclk;

  task automatic model_clear();
    q.delete();
    m_busy = 1'b0;
    m_en   = 1'b0;
    m_data = '0;
    m_prev = 1'b0;
  endtask

  // Advance one edge; the model sees the same inputs the DUT samples.
  task automatic cyc();
    logic aack;
    logic push;
    aack = aq2_ack ^ m_prev;
    push = ain_valid && (q.size() < DEPTH);
    if (q.size() > 0 && (!m_busy || aack)) begin
      m_data = q.pop_front();
      m_en   = ~m_en;
      m_busy = 1'b1;
    end else if (m_busy && aack) begin
      m_busy = 1'b0;
    end
    if (push) q.push_back(ain_data);
    m_prev = aq2_ack;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    @(posedge aclk);
    #1;
    arst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    ain_valid = 1'b0;
    ain_data  = '0;
    aq2_ack   = 1'b0;
    arst      = 1'b1;
    #2;
    checks++; if (adata !== 8'h00) begin failures++; $display("FAIL reset_adata got=%h exp=00", adata); end
    checks++; if (a_en !== 1'b0) begin failures++; $display("FAIL reset_a_en got=%b exp=0", a_en); end
    checks++; if (abusy !== 1'b0) begin failures++; $display("FAIL reset_abusy got=%b exp=0", abusy); end
    checks++; if (acount !== 3'd0) begin failures++; $display("FAIL reset_acount got=%0d exp=0", acount); end
    checks++; if (ain_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ain_ready); end
    checks++; if (atimeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", atimeout); end
    @(posedge aclk);
    #1;
    arst = 1'b0;
    model_clear();
  endtask

  task automatic test_single();
    ain_data  = 8'hA5;
    ain_valid = 1'b1;
    cyc();
    ain_valid = 1'b0;
    checks++; if (acount !== 3'd1) begin failures++; $display("FAIL single_cnt1 got=%0d exp=1", acount); end
    checks++; if (a_en !== 1'b0) begin failures++; $display("FAIL single_en_pre got=%b exp=0", a_en); end
    cyc();
    checks++; if (adata !== 8'hA5) begin failures++; $display("FAIL single_adata got=%h exp=a5", adata); end
    checks++; if (a_en !== 1'b1) begin failures++; $display("FAIL single_en got=%b exp=1", a_en); end
    checks++; if (abusy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", abusy); end
    checks++; if (acount !== 3'd0) begin failures++; $display("FAIL single_cnt0 got=%0d exp=0", acount); end
    aq2_ack = ~aq2_ack;
    cyc();
    checks++; if (abusy !== 1'b0) begin failures++; $display("FAIL single_done got=%b exp=0", abusy); end
  endtask

  task automatic test_back_to_back();
    logic e0;
    e0 = a_en;
    for (int i = 1; i <= 3; i++) begin
      ain_data  = WIDTH'(i);
      ain_valid = 1'b1;
      cyc();
    end
    ain_valid = 1'b0;
    checks++; if (adata !== 8'h01) begin failures++; $display("FAIL b2b_first got=%h exp=01", adata); end
    checks++; if (acount !== 3'd2) begin failures++; $display("FAIL b2b_cnt got=%0d exp=2", acount); end
    cyc();
    checks++; if (adata !== 8'h01) begin failures++; $display("FAIL b2b_hold got=%h exp=01", adata); end
    for (int i = 2; i <= 3; i++) begin
      aq2_ack = ~aq2_ack;
      cyc();
      checks++; if (adata !== WIDTH'(i)) begin failures++; $display("FAIL b2b_relaunch got=%h exp=%h", adata, WIDTH'(i)); end
      checks++; if (abusy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", abusy); end
      cyc();
      checks++; if (adata !== WIDTH'(i)) begin failures++; $display("FAIL b2b_hold2 got=%h exp=%h", adata, WIDTH'(i)); end
    end
    aq2_ack = ~aq2_ack;
    cyc();
    checks++; if (abusy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", abusy); end
    checks++; if (a_en !== ~e0) begin failures++; $display("FAIL b2b_toggles got=%b exp=%b", a_en, ~e0); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      ain_data  = WIDTH'(8'h10 + i);
      ain_valid = 1'b1;
      cyc();
    end
    checks++; if (adata !== 8'h10) begin failures++; $display("FAIL full_adata got=%h exp=10", adata); end
    checks++; if (acount !== 3'd4) begin failures++; $display("FAIL full_cnt got=%0d exp=4", acount); end
    checks++; if (ain_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", ain_ready); end
    ain_data = 8'h99;
    aq2_ack  = ~aq2_ack;
    cyc();
    ain_valid = 1'b0;
    checks++; if (acount !== 3'd3) begin failures++; $display("FAIL full_nopush got=%0d exp=3", acount); end
    checks++; if (ain_ready !== 1'b1) begin failures++; $display("FAIL full_ready2 got=%b exp=1", ain_ready); end
    checks++; if (adata !== 8'h11) begin failures++; $display("FAIL full_pop got=%h exp=11", adata); end
    for (int k = 2; k <= 4; k++) begin
      aq2_ack = ~aq2_ack;
      cyc();
      checks++; if (adata !== WIDTH'(8'h10 + k)) begin failures++; $display("FAIL full_order got=%h exp=%h", adata, WIDTH'(8'h10 + k)); end
    end
    aq2_ack = ~aq2_ack;
    cyc();
    checks++; if (abusy !== 1'b0) begin failures++; $display("FAIL full_drain got=%b exp=0", abusy); end
  endtask

  task automatic test_spurious();
    logic             e0;
    logic [WIDTH-1:0] d0;
    e0 = a_en;
    d0 = adata;
    aq2_ack = ~aq2_ack;
    cyc();
    cyc();
    checks++; if (a_en !== e0) begin failures++; $display("FAIL spur_en got=%b exp=%b", a_en, e0); end
    checks++; if (adata !== d0) begin failures++; $display("FAIL spur_adata got=%h exp=%h", adata, d0); end
    checks++; if (abusy !== 1'b0) begin failures++; $display("FAIL spur_busy got=%b exp=0", abusy); end
  endtask

  task automatic test_timeout();
    logic exp_to;
`ifdef MCP_SEND_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    ain_data  = 8'h5A;
    ain_valid = 1'b1;
    cyc();
    ain_valid = 1'b0;
    cyc();
    for (int i = 0; i < TMO - 1; i++) cyc();
    checks++; if (atimeout !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", atimeout); end
    cyc();
    checks++; if (atimeout !== exp_to) begin failures++; $display("FAIL tmo_set got=%b exp=%b", atimeout, exp_to); end
    checks++; if (abusy !== 1'b1) begin failures++; $display("FAIL tmo_wait got=%b exp=1", abusy); end
    aq2_ack = ~aq2_ack;
    cyc();
    cyc();
    checks++; if (atimeout !== exp_to) begin failures++; $display("FAIL tmo_sticky got=%b exp=%b", atimeout, exp_to); end
    checks++; if (abusy !== 1'b0) begin failures++; $display("FAIL tmo_late_ack got=%b exp=0", abusy); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      ain_data  = WIDTH'(8'hC0 + i);
      ain_valid = 1'b1;
      cyc();
    end
    ain_valid = 1'b0;
    checks++; if (acount !== 3'd3) begin failures++; $display("FAIL rmid_pre got=%0d exp=3", acount); end
    do_reset();
    checks++; if (adata !== 8'h00) begin failures++; $display("FAIL rmid_adata got=%h exp=00", adata); end
    checks++; if (a_en !== 1'b0) begin failures++; $display("FAIL rmid_en got=%b exp=0", a_en); end
    checks++; if (acount !== 3'd0) begin failures++; $display("FAIL rmid_cnt got=%0d exp=0", acount); end
    checks++; if (abusy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", abusy); end
    checks++; if (ain_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", ain_ready); end
    checks++; if (atimeout !== 1'b0) begin failures++; $display("FAIL rmid_tmo got=%b exp=0", atimeout); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      ain_valid = 1'($urandom_range(0, 1));
      ain_data  = WIDTH'($urandom);
      if ($urandom_range(0, 2) == 0) aq2_ack = ~aq2_ack;
      cyc();
      checks++;
      if (adata !== m_data || a_en !== m_en || abusy !== m_busy ||
          acount !== 3'(q.size()) || ain_ready !== (q.size() < DEPTH)) begin
        failures++;
        $display("FAIL rand_%0d got d=%h e=%b b=%b c=%0d r=%b exp d=%h e=%b b=%b c=%0d r=%b",
                 n, adata, a_en, abusy, acount, ain_ready,
                 m_data, m_en, m_busy, q.size(), (q.size() < DEPTH));
      end
    end
    ain_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_spurious();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
